// File: rtl/segment_scheduler_pkg.sv
// Shared constants and state type for the modulation/STM segment schedulers.
package segment_scheduler_pkg;

  localparam logic [15:0] SEGMENT_REP_INFINITE = 16'hFFFF;

  localparam int MOD_DEPTH = 32768;
  localparam int STM_DEPTH = 65536;

  typedef enum logic [1:0] {
    RUN,
    WAIT_SWAP,
    STOPPED
  } sched_state_t;

endpackage

// File: rtl/segment_scheduler_loop_counter.sv
// Saturating 16-bit loop counter with clear/increment and equality compare against the repeat count.
module loop_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic [15:0] rep,
  output logic [15:0] cnt,
  output logic        eq
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign eq = (cnt == rep);

endmodule

// File: rtl/segment_scheduler.sv
// Read segment / index / loop sequencer for one double-buffered memory (modulation or STM).
// Define SEGMENT_SCHEDULER_IMMEDIATE_SWAP_EN to apply a pending swap on the next STEP instead of at the wrap point.
module segment_scheduler
  import segment_scheduler_pkg::*;
#(
  parameter int DEPTH = MOD_DEPTH,
  localparam int W = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         UPDATE,
  input  logic         REQ_RD_SEGMENT,
  input  logic [15:0]  CYCLE_0,
  input  logic [15:0]  CYCLE_1,
  input  logic [15:0]  REP_0,
  input  logic [15:0]  REP_1,
  input  logic         STEP,
  output logic         SEGMENT,
  output logic [W-1:0] IDX,
  output logic         STOP,
  output logic         SWAP_PENDING
);

  logic [W-1:0] cyc0_q, cyc1_q, cyc_sel;
  logic [15:0]  rep0_q, rep1_q, rep_sel;
  logic         req_q, upd_q;

  sched_state_t state_q, state_n, eff;
  logic         seg_q, seg_n;
  logic [W-1:0] idx_q, idx_n;
  logic         do_swap, wrap, finite;

  logic         cnt_clr, cnt_inc, cnt_eq;
  logic [15:0]  cnt;

  function automatic logic [W-1:0] sat_cyc(input logic [15:0] c);
    if ({16'd0, c} >= 32'(DEPTH)) return W'(DEPTH - 1);
    return W'(c);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc0_q <= '0;
      cyc1_q <= '0;
      rep0_q <= SEGMENT_REP_INFINITE;
      rep1_q <= SEGMENT_REP_INFINITE;
      req_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      upd_q <= UPDATE;
      if (UPDATE) begin
        cyc0_q <= sat_cyc(CYCLE_0);
        cyc1_q <= sat_cyc(CYCLE_1);
        rep0_q <= REP_0;
        rep1_q <= REP_1;
        req_q  <= REQ_RD_SEGMENT;
      end
    end
  end

  assign cyc_sel = seg_q ? cyc1_q : cyc0_q;
  assign rep_sel = seg_q ? rep1_q : rep0_q;
  assign finite  = (rep_sel != SEGMENT_REP_INFINITE);
  assign wrap    = (idx_q >= cyc_sel);

  loop_counter u_loop (
    .clk (CLK),
    .rst (RST),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .rep (rep_sel),
    .cnt (cnt),
    .eq  (cnt_eq)
  );

  // The settled UPDATE first picks the effective state; a STEP in the same
  // cycle is then evaluated in that state, except when leaving STOPPED by swap.
  always_comb begin
    state_n = state_q;
    seg_n   = seg_q;
    idx_n   = idx_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    eff     = state_q;
    do_swap = 1'b0;

    if (upd_q) begin
      case (state_q)
        RUN:       if (req_q != seg_q) eff = WAIT_SWAP;
        WAIT_SWAP: if (req_q == seg_q) eff = RUN;
        STOPPED: begin
          if (req_q != seg_q) do_swap = 1'b1;
          else if (!finite || (rep_sel > cnt)) eff = RUN;
        end
        default: eff = state_q;
      endcase
    end

    state_n = eff;

    if (!do_swap && STEP) begin
      case (eff)
        RUN: begin
          if (wrap) begin
            if (finite && cnt_eq) begin
              state_n = STOPPED;
              idx_n   = cyc_sel;
            end else begin
              idx_n   = '0;
              cnt_inc = 1'b1;
            end
          end else begin
            idx_n = idx_q + W'(1);
          end
        end
        WAIT_SWAP: begin
`ifdef SEGMENT_SCHEDULER_IMMEDIATE_SWAP_EN
          do_swap = 1'b1;
`else
          if (wrap) do_swap = 1'b1;
          else      idx_n   = idx_q + W'(1);
`endif
        end
        default: ;
      endcase
    end

    if (do_swap) begin
      state_n = RUN;
      seg_n   = req_q;
      idx_n   = '0;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= RUN;
      seg_q        <= 1'b0;
      idx_q        <= '0;
      STOP         <= 1'b0;
      SWAP_PENDING <= 1'b0;
    end else begin
      state_q      <= state_n;
      seg_q        <= seg_n;
      idx_q        <= idx_n;
      STOP         <= (state_n == STOPPED);
      SWAP_PENDING <= (state_n == WAIT_SWAP);
    end
  end

  assign SEGMENT = seg_q;
  assign IDX     = idx_q;

endmodule

// File: tb/tb_segment_scheduler.sv
// Bench for segment_scheduler: directed vector table, hand sequences and a randomized run against a reference model.
module tb_segment_scheduler;

  localparam int TB_DEPTH = 16;
  localparam int W        = $clog2(TB_DEPTH);
  localparam int INF      = 65535;
`ifdef SEGMENT_SCHEDULER_IMMEDIATE_SWAP_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         UPDATE = 1'b0;
  logic         REQ_RD_SEGMENT = 1'b0;
  logic [15:0]  CYCLE_0 = '0, CYCLE_1 = '0, REP_0 = '0, REP_1 = '0;
  logic         STEP = 1'b0;
  logic         SEGMENT;
  logic [W-1:0] IDX;
  logic         STOP, SWAP_PENDING;

  segment_scheduler #(.DEPTH(TB_DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .UPDATE         (UPDATE),
    .REQ_RD_SEGMENT (REQ_RD_SEGMENT),
    .CYCLE_0        (CYCLE_0),
    .CYCLE_1        (CYCLE_1),
    .REP_0          (REP_0),
    .REP_1          (REP_1),
    .STEP           (STEP),
    .SEGMENT        (SEGMENT),
    .IDX            (IDX),
    .STOP           (STOP),
    .SWAP_PENDING   (SWAP_PENDING)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: shadow settings, current position and two flags.
  int m_seg, m_idx, m_loops, m_req;
  bit m_stopped, m_pending, m_upd_prev;
  int m_cyc[2], m_rep[2];

  function automatic int sat(input int c);
    return (c >= TB_DEPTH) ? TB_DEPTH - 1 : c;
  endfunction

  task automatic model_reset();
    m_seg = 0; m_idx = 0; m_loops = 0; m_req = 0;
    m_stopped = 0; m_pending = 0; m_upd_prev = 0;
    m_cyc[0] = 0; m_cyc[1] = 0; m_rep[0] = INF; m_rep[1] = INF;
  endtask

  task automatic model_cycle(input bit upd, input bit req, input int c0, input int c1,
                             input int r0, input int r1, input bit step);
    bit swap;
    bit wrap;
    swap = 0;
    if (m_upd_prev) begin
      if (m_stopped) begin
        if (m_req != m_seg) swap = 1;
        else if (m_rep[m_seg] == INF || m_rep[m_seg] > m_loops) m_stopped = 0;
      end else begin
        m_pending = (m_req != m_seg);
      end
    end
    if (!swap && step && !m_stopped) begin
      wrap = (m_idx >= m_cyc[m_seg]);
      if (m_pending && (IMM || wrap)) swap = 1;
      else if (wrap) begin
        if (m_rep[m_seg] != INF && m_loops == m_rep[m_seg]) begin
          m_stopped = 1;
          m_idx = (m_idx < m_cyc[m_seg]) ? m_idx : m_cyc[m_seg];
        end else begin
          m_idx = 0;
          if (m_loops < INF) m_loops++;
        end
      end else begin
        m_idx++;
      end
    end
    if (swap) begin
      m_seg = m_req; m_idx = 0; m_loops = 0; m_stopped = 0; m_pending = 0;
    end
    if (upd) begin
      m_cyc[0] = sat(c0); m_cyc[1] = sat(c1);
      m_rep[0] = r0; m_rep[1] = r1; m_req = req;
    end
    m_upd_prev = upd;
  endtask

  task automatic apply(input bit rst, input bit upd, input bit req, input int c0, input int c1,
                       input int r0, input int r1, input bit step);
    @(negedge CLK);
    RST = rst; UPDATE = upd; REQ_RD_SEGMENT = req;
    CYCLE_0 = 16'(c0); CYCLE_1 = 16'(c1); REP_0 = 16'(r0); REP_1 = 16'(r1);
    STEP = step;
    if (rst) model_reset();
    else     model_cycle(upd, req, c0, c1, r0, r1, step);
    @(posedge CLK);
    #1;
    check("model_seg",  SEGMENT,      m_seg);
    check("model_idx",  IDX,          m_idx);
    check("model_stop", STOP,         m_stopped);
    check("model_pend", SWAP_PENDING, m_pending);
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_upd(input bit req, input int c0, input int c1, input int r0, input int r1,
                        input bit step);
    apply(0, 1, req, c0, c1, r0, r1, step);
  endtask

  task automatic do_cyc(input bit step);
    apply(0, 0, 0, 0, 0, 0, 0, step);
  endtask

  typedef struct {
    bit rst, upd, req;
    int c0, c1, r0, r1;
    bit step;
    int e_seg, e_idx;
    bit e_stop;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit upd, input bit req, input int c0, input int c1,
                              input int r0, input int r1, input bit step,
                              input int e_seg, input int e_idx, input bit e_stop);
    vec_t v;
    v.rst = rst; v.upd = upd; v.req = req;
    v.c0 = c0; v.c1 = c1; v.r0 = r0; v.r1 = r1; v.step = step;
    v.e_seg = e_seg; v.e_idx = e_idx; v.e_stop = e_stop;
    return v;
  endfunction

  vec_t tbl[$];
  int a_idx[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
  int b_idx[8]  = '{1, 2, 0, 1, 2, 2, 2, 2};

  initial begin
    // Free-running loop of length 4
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 0, INF, INF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0));
    foreach (a_idx[i]) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, a_idx[i], 0));
    // REP = 1 plays two loops then stops
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0, 1,   INF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0));
    foreach (b_idx[i]) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, b_idx[i], i >= 5));
    // Swap out of STOPPED
    tbl.push_back(mk(0, 1, 1, 2, 4, 1,   INF, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,   1, 1, 1, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].upd, tbl[i].req, tbl[i].c0, tbl[i].c1, tbl[i].r0, tbl[i].r1, tbl[i].step);
      check($sformatf("tbl%0d_seg", i),  SEGMENT, tbl[i].e_seg);
      check($sformatf("tbl%0d_idx", i),  IDX,     tbl[i].e_idx);
      check($sformatf("tbl%0d_stop", i), STOP,    tbl[i].e_stop);
    end

    // Pending swap from RUN at IDX 3 with CYCLE_0 = 7
    do_reset();
    do_upd(0, 7, 5, INF, INF, 0);
    do_cyc(0);
    repeat (3) do_cyc(1);
    check("swap_idx3", IDX, 3);
    do_upd(1, 7, 5, INF, INF, 0);
    do_cyc(0);
    check("swap_pending", SWAP_PENDING, 1);
`ifdef SEGMENT_SCHEDULER_IMMEDIATE_SWAP_EN
    do_cyc(1);
    check("swap_imm_seg", SEGMENT, 1);
    check("swap_imm_idx", IDX, 0);
`else
    repeat (4) do_cyc(1);
    check("swap_hold_idx", IDX, 7);
    check("swap_hold_seg", SEGMENT, 0);
    do_cyc(1);
    check("swap_wrap_seg", SEGMENT, 1);
    check("swap_wrap_idx", IDX, 0);
`endif
    check("swap_done_pend", SWAP_PENDING, 0);

    // UPDATE and STEP together at the wrap point, shrinking the cycle to 2
    do_reset();
    do_upd(0, 3, 0, INF, INF, 0);
    do_cyc(0);
    repeat (3) do_cyc(1);
    do_upd(0, 1, 0, INF, INF, 1);
    check("shrink_wrap_idx", IDX, 0);
    for (int k = 0; k < 4; k++) begin
      do_cyc(1);
      check($sformatf("shrink_alt%0d", k), IDX, (k % 2 == 0) ? 1 : 0);
    end

    // Reset while a swap is pending
    do_reset();
    do_upd(0, 7, 5, INF, INF, 0);
    do_cyc(0);
    do_cyc(1);
    do_upd(1, 7, 5, INF, INF, 0);
    do_cyc(0);
    check("rst_pre_pend", SWAP_PENDING, 1);
    do_reset();
    check("rst_seg", SEGMENT, 0);
    check("rst_idx", IDX, 0);
    check("rst_pend", SWAP_PENDING, 0);
    do_cyc(1);
    check("rst_cyc_zero", IDX, 0);

    // Cycle above DEPTH saturates to DEPTH-1
    do_reset();
    do_upd(0, 100, 0, INF, INF, 0);
    do_cyc(0);
    for (int k = 1; k <= TB_DEPTH; k++) begin
      do_cyc(1);
      check($sformatf("sat_idx%0d", k), IDX, k % TB_DEPTH);
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r, u, q, s;
      int c0, c1, r0, r1;
      r  = ($urandom_range(0, 299) == 0);
      u  = ($urandom_range(0, 7) == 0);
      q  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      c0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
      c1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
      r0 = ($urandom_range(0, 3) == 0) ? INF : int'($urandom_range(0, 2));
      r1 = ($urandom_range(0, 3) == 0) ? INF : int'($urandom_range(0, 2));
      apply(r, u, q, c0, c1, r0, r1, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/segment_scheduler.md
# segment_scheduler

Sequencer for the double-buffered modulation and STM memories: owns the read segment, read index and loop counter for one of them. It accepts segment/cycle/repeat settings from the controller register file and advances the index on externally generated frequency-divided step pulses. It swaps segments only at loop boundaries and stops after a finite repeat count. One instance drives modulation, a second drives STM.

## Interface
Parameters:
- DEPTH, 32768, entries per segment; index width W = $clog2(DEPTH)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- UPDATE  in  1  one-cycle pulse; controller register write to the mod/STM settings is complete (CTL_FLAG_MOD_SET_BIT / CTL_FLAG_STM_SET_BIT)
- REQ_RD_SEGMENT  in  1  requested read segment
- CYCLE_0, CYCLE_1  in  16 each  last index (length−1) of segment 0/1
- REP_0, REP_1  in  16 each  repeat count of segment 0/1; 16'hFFFF = infinite
- STEP  in  1  one-cycle advance pulse from frequency divider
- SEGMENT  out  1  current read segment
- IDX  out  W  current read index
- STOP  out  1  finite repeat exhausted; index frozen
- SWAP_PENDING  out  1  swap requested, not yet applied

## Operation
- Shadow registers cyc[2], rep[2], req are loaded on UPDATE. Reset values: cyc = 0, rep = FFFF, req = 0.
- cyc values ≥ DEPTH saturate to DEPTH−1 at load.
- FSM states: RUN, WAIT_SWAP, STOPPED. Reset: RUN, SEGMENT 0, IDX 0, STOP 0, SWAP_PENDING 0, loop_cnt 0.
- Wrap point: STEP while IDX ≥ cyc[SEGMENT]. The ≥ covers a cycle length shrunk below the current IDX.
- RUN, STEP, not wrap: IDX+1.
- RUN, wrap:
  - If rep[SEGMENT] ≠ FFFF and loop_cnt == rep[SEGMENT]: go to STOPPED, STOP = 1, IDX held at min(IDX, cyc).
  - Otherwise: IDX = 0, loop_cnt+1.
  - REP = n therefore plays n+1 loops.
- WAIT_SWAP, wrap: SEGMENT = req, IDX = 0, loop_cnt = 0, go to RUN, SWAP_PENDING = 0. The finite-repeat stop check is not applied on this wrap.
- STOPPED: STEP is ignored.
- UPDATE with req ≠ SEGMENT:
  - From STOPPED: swap on the next cycle. SEGMENT = req, IDX 0, loop_cnt 0, STOP 0, go to RUN.
  - From RUN: go to WAIT_SWAP.
- UPDATE with req == SEGMENT:
  - From WAIT_SWAP: cancel the swap and go to RUN.
  - From RUN or STOPPED: only the shadow values change; loop_cnt is kept. If STOPPED and the new rep > loop_cnt, or the new rep = FFFF, return to RUN. The next STEP then wraps.
- loop_cnt is 16-bit and saturates at FFFF. It never rolls over.

## Timing
- All outputs registered.
- STEP at cycle t updates IDX/SEGMENT/STOP at t+1.
- UPDATE at t loads the shadows at t+1. State or segment changes caused by UPDATE are visible at t+2.
- UPDATE and STEP in the same cycle: STEP is evaluated against the old shadows and state. UPDATE is then applied to the post-STEP state one cycle later.
- Consecutive UPDATEs: the last one wins. No queueing.
- RST asserted mid-loop or mid-swap: all state returns to reset values immediately. Downstream sees segment 0, index 0.

## Configuration
- SEGMENT_SCHEDULER_IMMEDIATE_SWAP_EN
  - Defined: a pending swap is applied on the next STEP rather than at the wrap point (SEGMENT = req, IDX 0, loop_cnt 0).
  - Undefined: swaps occur only at the wrap point or immediately from STOPPED, as above.
  - All other behaviour is identical.

## Structure
- Shared params package:
  - SEGMENT_REP_INFINITE = 16'hFFFF
  - typedef enum sched_state_t {RUN, WAIT_SWAP, STOPPED}
  - the MOD and STM DEPTH constants
- Sub-module: loop_counter. It holds the 16-bit saturating counter with clear/increment and an equality compare against rep. Everything else (FSM, index counter, shadows) stays in segment_scheduler.

## Test plan
- Reset, then UPDATE with CYCLE_0 = 3, REP_0 = FFFF, then 10 STEPs → IDX sequence 1,2,3,0,1,2,3,0,1,2; STOP never asserts.
- CYCLE_0 = 2, REP_0 = 1, then 8 STEPs → IDX 1,2,0,1,2 then held at 2; STOP = 1 on the cycle after the 6th STEP; further STEPs ignored.
- While STOPPED on seg 0: UPDATE with REQ_RD_SEGMENT = 1, CYCLE_1 = 4 → two cycles later SEGMENT = 1, IDX 0, STOP 0.
- Running seg 0 (CYCLE_0 = 7) at IDX 3: UPDATE with req = 1 → SWAP_PENDING = 1; SEGMENT changes only after the STEP at IDX 7. With the macro defined, it changes on the next STEP, with IDX 0.
- UPDATE and STEP in the same cycle at the wrap point with new CYCLE_0 = 1 → IDX 0 at t+1; the following STEPs alternate 1,0. Also: RST pulse while WAIT_SWAP → SEGMENT 0, IDX 0, SWAP_PENDING 0.
